mem_dump_reader: RTL and testbench

- Debug-side reader for the data memory: on command, it walks a range of word addresses and streams each 32-bit word as 4 bytes to the UART transmitter.
- Sits between the debug unit (command/status), the data memory read port (address/Re/size_control in, o_Data back) and the UART TX (start/done handshake).
- Runs only while the pipeline is halted; it never writes memory.

---
 rtl/mem_dump_reader_pkg.sv | 23 ++
 rtl/word_to_byte_serializer.sv | 41 ++++
 rtl/mem_dump_reader.sv | 137 +++++++++++++
 tb/tb_mem_dump_reader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_reader_pkg.sv
// Shared definitions for the debug memory dump reader: FSM encoding, memory access size, word geometry.
package mem_dump_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_LATCH   = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_TX = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Full word, no sign extension, no write.
    localparam logic [4:0] SIZE_WORD      = 5'b00000;
    localparam int         BYTES_PER_WORD = 4;
    localparam int         BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    function automatic logic [7:0] top_byte(input logic [31:0] w);
        return w[31:24];
    endfunction

endpackage

// File: rtl/word_to_byte_serializer.sv
// Holds one memory word and hands it to the UART MSB first, one byte per start pulse.
// tx_start is registered: it is high in the cycle after a load or an advance.
module word_to_byte_serializer
    import mem_dump_reader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        advance,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        last_byte
);

    logic [31:0]           shift;
    logic [BYTE_IDX_W-1:0] byte_idx;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shift    <= '0;
            byte_idx <= '0;
            tx_start <= 1'b0;
        end else begin
            tx_start <= load || advance;
            if (load) begin
                shift    <= word;
                byte_idx <= '0;
            end else if (advance) begin
                shift    <= {shift[23:0], 8'h00};
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

    // The outgoing byte always sits in the top lane, so it is stable across WAIT_TX.
    assign tx_data   = top_byte(shift);
    assign last_byte = (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_dump_reader.sv
// Walks a range of data-memory words and streams each as 4 bytes (MSB first) to the UART TX.
// First byte starts 3 cycles after i_start; byte pacing follows i_tx_done; i_abort drops to idle silently.
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter int MEM_SIZE    = 1024,
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32,
    parameter int CNT_WIDTH   = $clog2(MEM_SIZE) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [ADDR_LENGTH-1:0] i_base_addr,
    input  logic [CNT_WIDTH-1:0]   i_word_count,
    output logic [ADDR_LENGTH-1:0] o_mem_addr,
    output logic                   o_mem_re,
    output logic [4:0]             o_size_control,
    input  logic [DATA_LENGTH-1:0] i_mem_data,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int AW = $clog2(MEM_SIZE);

    state_t               state;
    logic [AW-1:0]        addr;
    logic [CNT_WIDTH-1:0] remaining;
    logic [CNT_WIDTH-1:0] count_clamped;
    logic                 mem_re;
    logic                 busy;
    logic                 done;
    logic                 ser_load;
    logic                 ser_advance;
    logic                 last_byte;
    logic                 unused_base_hi;

    // Only the low AW bits of the base address select a word; the rest wrap away.
    assign unused_base_hi = ^i_base_addr[ADDR_LENGTH-1:AW];

    assign count_clamped = (i_word_count > CNT_WIDTH'(MEM_SIZE)) ? CNT_WIDTH'(MEM_SIZE)
                                                                 : i_word_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst || i_abort) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            mem_re    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        busy <= 1'b1;
                        if (i_word_count == '0) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            addr      <= i_base_addr[AW-1:0];
                            remaining <= count_clamped;
                            mem_re    <= 1'b1;
                            state     <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    mem_re <= 1'b0;
                    state  <= ST_SEND;
                end
                ST_SEND: begin
                    state <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        state <= last_byte ? ST_NEXT : ST_SEND;
                    end
                end
                ST_NEXT: begin
                    if (remaining == CNT_WIDTH'(1)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        remaining <= remaining - 1'b1;
                        addr      <= addr + 1'b1;
                        mem_re    <= 1'b1;
                        state     <= ST_ADDR;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    mem_re <= 1'b0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory data is valid during LATCH (one cycle after the address), captured at its end.
    assign ser_load    = (state == ST_LATCH);
    assign ser_advance = (state == ST_WAIT_TX) && i_tx_done && !last_byte;

    word_to_byte_serializer u_serializer (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .clear     (i_abort),
        .load      (ser_load),
        .word      (i_mem_data[31:0]),
        .advance   (ser_advance),
        .tx_start  (o_tx_start),
        .tx_data   (o_tx_data),
        .last_byte (last_byte)
    );

    assign o_mem_addr     = {{(ADDR_LENGTH-AW){1'b0}}, addr};
    assign o_mem_re       = mem_re;
    assign o_size_control = SIZE_WORD;
    assign o_busy         = busy;
    assign o_done         = done;

    a_re_only_busy: assert property (@(posedge i_clk) disable iff (!i_rst) o_mem_re |-> o_busy);
    a_tx_only_busy: assert property (@(posedge i_clk) disable iff (!i_rst) o_tx_start |-> o_busy);

endmodule

// File: tb/tb_mem_dump_reader.sv
// Randomized bench for mem_dump_reader against a word-list/byte-stream reference model.
module tb_mem_dump_reader;

    localparam int MEM_SIZE = 1024;
    localparam int AL       = 32;
    localparam int DL       = 32;
    localparam int CW       = $clog2(MEM_SIZE) + 1;
    localparam int AW       = $clog2(MEM_SIZE);

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_tx_done = 1'b0;
    logic [AL-1:0] i_base_addr = '0;
    logic [CW-1:0] i_word_count = '0;
    logic [AL-1:0] o_mem_addr;
    logic          o_mem_re;
    logic [4:0]    o_size_control;
    logic [DL-1:0] i_mem_data;
    logic [7:0]    o_tx_data;
    logic          o_tx_start;
    logic          o_busy;
    logic          o_done;

    logic [31:0] mem [MEM_SIZE];
    assign i_mem_data = mem[o_mem_addr[AW-1:0]];

    mem_dump_reader #(
        .MEM_SIZE    (MEM_SIZE),
        .ADDR_LENGTH (AL),
        .DATA_LENGTH (DL),
        .CNT_WIDTH   (CW)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_base_addr    (i_base_addr),
        .i_word_count   (i_word_count),
        .o_mem_addr     (o_mem_addr),
        .o_mem_re       (o_mem_re),
        .o_size_control (o_size_control),
        .i_mem_data     (i_mem_data),
        .o_tx_data      (o_tx_data),
        .o_tx_start     (o_tx_start),
        .i_tx_done      (i_tx_done),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    always #5 i_clk = ~i_clk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    logic [7:0]  got_bytes [$];
    int          start_cyc [$];
    int          delay_q   [$];
    logic [31:0] addr_log  [$];
    int          done_cnt   = 0;
    bit          rand_delay = 0;
    int          fixed_delay = 5;
    bit          spur_send  = 0;
    bit          spur_idle  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // UART TX model plus bus monitor, all sampled on the falling edge.
    initial begin : tx_model
        int pending;
        int d;
        pending = 0;
        forever begin
            @(negedge i_clk);
            i_tx_done = 1'b0;
            if (pending > 0) begin
                pending--;
                if (pending == 0) i_tx_done = 1'b1;
            end
            if (o_tx_start) begin
                d = rand_delay ? int'($urandom_range(1, 6)) : fixed_delay;
                got_bytes.push_back(o_tx_data);
                start_cyc.push_back(cyc);
                delay_q.push_back(d);
                pending = d;
                if (spur_send) i_tx_done = 1'b1;
            end
            if (spur_idle && !o_busy && pending == 0) i_tx_done = 1'b1;
            if (o_mem_re) addr_log.push_back(o_mem_addr);
            if (o_done) done_cnt++;
        end
    end

    task automatic clear_logs();
        got_bytes.delete();
        start_cyc.delete();
        delay_q.delete();
        addr_log.delete();
        done_cnt = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, o_busy, 0);
        check_val({tag, "_re"}, o_mem_re, 0);
        check_val({tag, "_txs"}, o_tx_start, 0);
        check_val({tag, "_txd"}, o_tx_data, 0);
        check_val({tag, "_addr"}, o_mem_addr, 0);
        check_val({tag, "_done"}, o_done, 0);
    endtask

    task automatic run_dump(input logic [31:0] base, input int cnt, input bit restart);
        int          n;
        int          k;
        int          done_at;
        int          budget;
        int          last;
        logic [31:0] a;
        logic [31:0] w;
        logic [7:0]  exp_bytes [$];
        logic [31:0] exp_addr  [$];
        n = (cnt > MEM_SIZE) ? MEM_SIZE : cnt;
        for (int i = 0; i < n; i++) begin
            a = ((base % 32'(MEM_SIZE)) + 32'(i)) % 32'(MEM_SIZE);
            w = mem[a[AW-1:0]];
            exp_addr.push_back(a);
            exp_addr.push_back(a);
            for (int b = 0; b < 4; b++) exp_bytes.push_back(8'(w >> (24 - 8 * b)));
        end
        clear_logs();
        @(negedge i_clk);
        i_base_addr  = base;
        i_word_count = CW'(cnt);
        i_start      = 1'b1;
        k            = cyc;
        done_at      = -1;
        budget       = 40 + n * 48;
        for (int c = 0; c < budget && done_at < 0; c++) begin
            @(negedge i_clk);
            i_start = (restart && c == 6) ? 1'b1 : 1'b0;
            if (restart && c == 6) i_base_addr = base ^ 32'h5;
            if (o_done) done_at = cyc;
        end
        i_start = 1'b0;
        check_val("done_seen", done_at >= 0, 1);
        @(negedge i_clk);
        check_val("busy_after", o_busy, 0);
        @(negedge i_clk);
        check_val("done_count", done_cnt, 1);
        check_val("size_ctl", o_size_control, 0);
        check_val("n_bytes", got_bytes.size(), exp_bytes.size());
        check_val("n_reads", addr_log.size(), exp_addr.size());
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            check_val("byte", got_bytes[i], exp_bytes[i]);
        for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++)
            check_val("mem_addr", addr_log[i], exp_addr[i]);
        if (n == 0) begin
            check_val("lat_zero", done_at - k, 1);
        end else if (got_bytes.size() == exp_bytes.size() && done_at >= 0) begin
            check_val("lat_first", start_cyc[0] - k, 3);
            for (int i = 1; i < start_cyc.size(); i++)
                check_val("byte_gap", start_cyc[i] - start_cyc[i-1],
                          delay_q[i-1] + (((i % 4) == 0) ? 4 : 1));
            last = start_cyc.size() - 1;
            check_val("lat_done", done_at - start_cyc[last], delay_q[last] + 2);
        end
    endtask

    task automatic abort_mid(input logic [31:0] base, input int cnt, input int nbytes, input bit use_rst);
        int nb;
        clear_logs();
        @(negedge i_clk);
        i_base_addr  = base;
        i_word_count = CW'(cnt);
        i_start      = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int c = 0; c < 500 && got_bytes.size() < nbytes; c++) @(negedge i_clk);
        check_val(use_rst ? "rst_reach" : "abort_reach", got_bytes.size() >= nbytes, 1);
        if (use_rst) i_rst = 1'b0;
        else         i_abort = 1'b1;
        @(negedge i_clk);
        i_rst   = 1'b1;
        i_abort = 1'b0;
        check_idle_outputs(use_rst ? "rst_mid" : "abort_mid");
        nb = got_bytes.size();
        repeat (20) @(negedge i_clk);
        check_val("stop_no_tx", got_bytes.size(), nb);
        check_val("stop_no_done", done_cnt, 0);
    endtask

    initial begin : main
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = $urandom;
        mem[0] = 32'h11223344;
        mem[1] = 32'hAABBCCDD;
        mem[2] = 32'h00000000;
        mem[3] = 32'hFFFFFFFF;

        repeat (3) @(negedge i_clk);
        check_idle_outputs("reset");
        i_rst = 1'b1;

        fixed_delay = 5;
        run_dump(32'd0, 2, 1'b0);
        run_dump($urandom, 0, 1'b0);
        run_dump(32'(MEM_SIZE - 1), 2, 1'b0);

        abort_mid(32'd0, 3, 2, 1'b0);
        run_dump(32'd0, 2, 1'b0);
        abort_mid(32'd5, 4, 6, 1'b1);
        run_dump(32'd5, 2, 1'b0);

        spur_send = 1'b1;
        spur_idle = 1'b1;
        run_dump(32'd2, 3, 1'b1);
        spur_send = 1'b0;
        spur_idle = 1'b0;

        // Abort and start together in IDLE: nothing may start.
        clear_logs();
        @(negedge i_clk);
        i_word_count = CW'(3);
        i_start      = 1'b1;
        i_abort      = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        check_val("abort_start_busy", o_busy, 0);
        repeat (6) @(negedge i_clk);
        check_val("abort_start_reads", addr_log.size(), 0);
        check_val("abort_start_tx", got_bytes.size(), 0);

        rand_delay = 1'b1;
        repeat (8) begin
            spur_send = 1'($urandom_range(0, 1));
            spur_idle = 1'($urandom_range(0, 1));
            run_dump($urandom, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        end
        spur_send = 1'b0;
        spur_idle = 1'b0;

        rand_delay  = 1'b0;
        fixed_delay = 1;
        run_dump(32'd17, MEM_SIZE + 5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
